// File: rtl/platform_pio_input_irq_pkg.sv
// Shared constants for the platform input PIO.
//   - Avalon word addresses of the four registers
//   - EDGE_TYPE and IRQ_TYPE parameter encodings
//   - debounce counter width helper
package platform_pio_pkg;

  localparam logic [1:0] ADDR_DATA     = 2'd0;
  localparam logic [1:0] ADDR_RSVD     = 2'd1;
  localparam logic [1:0] ADDR_IRQ_MASK = 2'd2;
  localparam logic [1:0] ADDR_EDGE_CAP = 2'd3;

  localparam int unsigned EDGE_NONE = 0;
  localparam int unsigned EDGE_RISE = 1;
  localparam int unsigned EDGE_FALL = 2;
  localparam int unsigned EDGE_ANY  = 3;

  localparam int unsigned IRQ_LEVEL = 0;
  localparam int unsigned IRQ_EDGE  = 1;

  // Counter must hold values 0..DEBOUNCE_CYCLES; at least one bit so the
  // declaration stays legal when debounce is disabled.
  function automatic int unsigned debounce_cnt_width(input int unsigned cycles);
    int unsigned w;
    w = $clog2(cycles + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/platform_pio_input_irq_if.sv
// Avalon-MM slave bus bundle for the platform input PIO.
//   address    : register word address
//   chipselect : slave select
//   write_n    : active-low write strobe
//   writedata  : write data
//   readdata   : registered read data
interface platform_pio_input_irq_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address,
    output chipselect,
    output write_n,
    output writedata,
    input  readdata
  );

  modport slave (
    input  address,
    input  chipselect,
    input  write_n,
    input  writedata,
    output readdata
  );
endinterface

// File: rtl/platform_pio_input_irq_input_bit.sv
// Per-pin input conditioning for the platform input PIO.
//   clk        : system clock
//   reset      : synchronous, active-high reset
//   pin        : asynchronous input pin
//   stable     : synchronised (and optionally debounced) pin value
//   edge_pulse : one-cycle pulse when stable makes the edge selected by EDGE_TYPE
module platform_pio_input_bit
  import platform_pio_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 0,
  parameter int unsigned EDGE_TYPE       = EDGE_RISE
) (
  input  logic clk,
  input  logic reset,
  input  logic pin,
  output logic stable,
  output logic edge_pulse
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   synced;
  logic                   stable_q;
  logic                   prev_q;
  logic                   rise;
  logic                   fall;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pin};
    end
  end

  assign synced = sync_q[SYNC_STAGES-1];

  if (DEBOUNCE_CYCLES == 0) begin : g_no_debounce
    always_ff @(posedge clk) begin
      if (reset) begin
        stable_q <= 1'b0;
      end else begin
        stable_q <= synced;
      end
    end
  end else begin : g_debounce
    localparam int unsigned CntW = debounce_cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            stable_d;

    // Accept a change only after DEBOUNCE_CYCLES consecutive differing samples;
    // any return to the stable value restarts the count.
    always_comb begin
      cnt_d    = cnt_q;
      stable_d = stable_q;
      if (synced == stable_q) begin
        cnt_d = '0;
      end else if (cnt_q == CntLast) begin
        stable_d = synced;
        cnt_d    = '0;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        cnt_q    <= '0;
        stable_q <= 1'b0;
      end else begin
        cnt_q    <= cnt_d;
        stable_q <= stable_d;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prev_q <= 1'b0;
    end else begin
      prev_q <= stable_q;
    end
  end

  assign rise = stable_q & ~prev_q;
  assign fall = ~stable_q & prev_q;

  always_comb begin
    edge_pulse = 1'b0;
    case (EDGE_TYPE)
      EDGE_RISE: edge_pulse = rise;
      EDGE_FALL: edge_pulse = fall;
      EDGE_ANY:  edge_pulse = rise | fall;
      default:   edge_pulse = 1'b0;
    endcase
  end

  assign stable = stable_q;

endmodule

// File: rtl/platform_pio_input_irq.sv
// Parametrised Avalon-MM input PIO with edge capture and masked interrupt.
//   clk     : system clock
//   reset   : synchronous, active-high reset
//   bus     : Avalon-MM slave (address, chipselect, write_n, writedata, readdata)
//   in_port : WIDTH asynchronous input pins
//   irq     : interrupt request, level or edge sourced per IRQ_TYPE
// Registers: 0 DATA (RO), 1 reserved (reads 0), 2 IRQ_MASK (RW), 3 EDGE_CAPTURE (W1C).
module platform_pio_input_irq
  import platform_pio_pkg::*;
#(
  parameter int unsigned WIDTH           = 4,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 0,
  parameter int unsigned EDGE_TYPE       = EDGE_RISE,
  parameter int unsigned IRQ_TYPE        = IRQ_LEVEL
) (
  input  logic                     clk,
  input  logic                     reset,
  platform_pio_input_irq_if.slave  bus,
  input  logic [WIDTH-1:0]         in_port,
  output logic                     irq
);

  logic [WIDTH-1:0] stable;
  logic [WIDTH-1:0] edge_pulse;
  logic [WIDTH-1:0] irq_mask_q, irq_mask_d;
  logic [WIDTH-1:0] edge_cap_q, edge_cap_d;
  logic [WIDTH-1:0] edge_clr;
  logic [WIDTH-1:0] rd_mux;
  logic [31:0]      readdata_q;
  logic             wr_en;
  logic             unused_wdata;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    platform_pio_input_bit #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .EDGE_TYPE       (EDGE_TYPE)
    ) u_bit (
      .clk        (clk),
      .reset      (reset),
      .pin        (in_port[i]),
      .stable     (stable[i]),
      .edge_pulse (edge_pulse[i])
    );
  end

  assign wr_en        = bus.chipselect & ~bus.write_n;
  assign unused_wdata = ^bus.writedata;

  always_comb begin
    irq_mask_d = irq_mask_q;
    edge_clr   = '0;
    if (wr_en) begin
      if (bus.address == ADDR_IRQ_MASK) begin
        irq_mask_d = bus.writedata[WIDTH-1:0];
      end
      if (bus.address == ADDR_EDGE_CAP) begin
        edge_clr = bus.writedata[WIDTH-1:0];
      end
    end
    // OR in new edges after the clear so a same-cycle edge survives the W1C.
    edge_cap_d = (edge_cap_q & ~edge_clr) | edge_pulse;
  end

  always_comb begin
    rd_mux = '0;
    unique case (bus.address)
      ADDR_DATA:     rd_mux = stable;
      ADDR_RSVD:     rd_mux = '0;
      ADDR_IRQ_MASK: rd_mux = irq_mask_q;
      ADDR_EDGE_CAP: rd_mux = edge_cap_q;
      default:       rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      irq_mask_q <= '0;
      edge_cap_q <= '0;
      readdata_q <= '0;
    end else begin
      irq_mask_q <= irq_mask_d;
      edge_cap_q <= edge_cap_d;
      readdata_q <= 32'(rd_mux);
    end
  end

  assign bus.readdata = readdata_q;

  if (IRQ_TYPE == IRQ_EDGE) begin : g_irq_edge
    assign irq = |(edge_cap_q & irq_mask_q);
  end else begin : g_irq_level
    assign irq = |(stable & irq_mask_q);
  end

endmodule

// File: tb/tb_platform_pio_input_irq.sv
module tb_platform_pio_input_irq;

  logic        clk;
  logic        rst;
  logic        rst_c;
  logic [3:0]  cs;
  logic        wr_n;
  logic [1:0]  addr;
  logic [31:0] wdata;
  logic [3:0]  in_a, in_b, in_c;
  logic [31:0] in_d;
  logic        irq_a, irq_b, irq_c, irq_d;
  int          n_checks;
  int          n_fail;

  platform_pio_input_irq_if bus_a ();
  platform_pio_input_irq_if bus_b ();
  platform_pio_input_irq_if bus_c ();
  platform_pio_input_irq_if bus_d ();

  assign bus_a.address = addr;  assign bus_a.chipselect = cs[0];
  assign bus_a.write_n = wr_n;  assign bus_a.writedata  = wdata;
  assign bus_b.address = addr;  assign bus_b.chipselect = cs[1];
  assign bus_b.write_n = wr_n;  assign bus_b.writedata  = wdata;
  assign bus_c.address = addr;  assign bus_c.chipselect = cs[2];
  assign bus_c.write_n = wr_n;  assign bus_c.writedata  = wdata;
  assign bus_d.address = addr;  assign bus_d.chipselect = cs[3];
  assign bus_d.write_n = wr_n;  assign bus_d.writedata  = wdata;

  // A: level irq, rising edges
  platform_pio_input_irq #(.WIDTH(4), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(0),
                           .EDGE_TYPE(1), .IRQ_TYPE(0)) dut_a (
    .clk(clk), .reset(rst), .bus(bus_a), .in_port(in_a), .irq(irq_a));
  // B: edge irq, falling edges
  platform_pio_input_irq #(.WIDTH(4), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(0),
                           .EDGE_TYPE(2), .IRQ_TYPE(1)) dut_b (
    .clk(clk), .reset(rst), .bus(bus_b), .in_port(in_b), .irq(irq_b));
  // C: debounce 4, rising edges, level irq
  platform_pio_input_irq #(.WIDTH(4), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4),
                           .EDGE_TYPE(1), .IRQ_TYPE(0)) dut_c (
    .clk(clk), .reset(rst_c), .bus(bus_c), .in_port(in_c), .irq(irq_c));
  // D: 32 bits, any edge
  platform_pio_input_irq #(.WIDTH(32), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(0),
                           .EDGE_TYPE(3), .IRQ_TYPE(0)) dut_d (
    .clk(clk), .reset(rst), .bus(bus_d), .in_port(in_d), .irq(irq_d));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic bus_write(input logic [3:0] sel, input logic [1:0] a, input logic [31:0] d);
    cs    = sel;
    wr_n  = 1'b0;
    addr  = a;
    wdata = d;
    tick(1);
    cs    = 4'b0;
    wr_n  = 1'b1;
  endtask

  task automatic bus_read(input logic [1:0] a);
    addr = a;
    tick(1);
  endtask

  task automatic test_reset;
    rst = 1'b1; rst_c = 1'b1;
    in_a = 4'hF; in_b = 4'h2; in_c = 4'h0; in_d = 32'h0;
    tick(2);
    n_checks++;
    if (bus_a.readdata !== 32'h0) begin
      $display("FAIL reset_readdata_a got=%h exp=%h", bus_a.readdata, 32'h0); n_fail++;
    end
    n_checks++;
    if (irq_a !== 1'b0) begin
      $display("FAIL reset_irq_a got=%b exp=0", irq_a); n_fail++;
    end
    n_checks++;
    if (bus_c.readdata !== 32'h0) begin
      $display("FAIL reset_readdata_c got=%h exp=%h", bus_c.readdata, 32'h0); n_fail++;
    end
    rst = 1'b0; rst_c = 1'b0;
    tick(6);
    bus_read(2'd0);
    n_checks++;
    if (bus_a.readdata !== 32'h0000000F) begin
      $display("FAIL data_after_reset got=%h exp=%h", bus_a.readdata, 32'hF); n_fail++;
    end
    bus_read(2'd2);
    n_checks++;
    if (bus_a.readdata !== 32'h0) begin
      $display("FAIL mask_after_reset got=%h exp=%h", bus_a.readdata, 32'h0); n_fail++;
    end
    bus_read(2'd3);
    n_checks++;
    if (bus_a.readdata !== 32'h0000000F) begin
      $display("FAIL edgecap_rise_after_reset got=%h exp=%h", bus_a.readdata, 32'hF); n_fail++;
    end
  endtask

  task automatic test_level_irq;
    in_a = 4'b0100;
    tick(5);
    bus_write(4'b0001, 2'd2, 32'h4);
    n_checks++;
    if (irq_a !== 1'b1) begin $display("FAIL level_irq_set got=%b exp=1", irq_a); n_fail++; end
    in_a = 4'b0000;
    tick(2);
    n_checks++;
    if (irq_a !== 1'b1) begin $display("FAIL level_irq_hold2 got=%b exp=1", irq_a); n_fail++; end
    tick(1);
    n_checks++;
    if (irq_a !== 1'b0) begin $display("FAIL level_irq_fall3 got=%b exp=0", irq_a); n_fail++; end
    in_a = 4'b0100;
    tick(4);
    n_checks++;
    if (irq_a !== 1'b1) begin $display("FAIL level_irq_reassert got=%b exp=1", irq_a); n_fail++; end
    bus_write(4'b0001, 2'd2, 32'h0);
    n_checks++;
    if (irq_a !== 1'b0) begin $display("FAIL level_irq_unmask got=%b exp=0", irq_a); n_fail++; end
  endtask

  task automatic test_edge_irq;
    bus_write(4'b0010, 2'd2, 32'h2);
    n_checks++;
    if (irq_b !== 1'b0) begin $display("FAIL edge_irq_idle got=%b exp=0", irq_b); n_fail++; end
    in_b = 4'b0000;
    tick(3);
    n_checks++;
    if (irq_b !== 1'b0) begin $display("FAIL edge_irq_early got=%b exp=0", irq_b); n_fail++; end
    tick(1);
    n_checks++;
    if (irq_b !== 1'b1) begin $display("FAIL edge_irq_set got=%b exp=1", irq_b); n_fail++; end
    bus_read(2'd3);
    n_checks++;
    if (bus_b.readdata !== 32'h2) begin
      $display("FAIL edgecap_fall got=%h exp=%h", bus_b.readdata, 32'h2); n_fail++;
    end
    bus_write(4'b0010, 2'd3, 32'h2);
    n_checks++;
    if (irq_b !== 1'b0) begin $display("FAIL edge_irq_clear got=%b exp=0", irq_b); n_fail++; end
    bus_read(2'd3);
    n_checks++;
    if (bus_b.readdata !== 32'h0) begin
      $display("FAIL edgecap_w1c got=%h exp=%h", bus_b.readdata, 32'h0); n_fail++;
    end
    in_b = 4'b0010;
    tick(5);
    in_b = 4'b0000;
    tick(3);
    // Clear lands on the same edge that captures the new falling edge.
    bus_write(4'b0010, 2'd3, 32'h2);
    n_checks++;
    if (irq_b !== 1'b1) begin $display("FAIL set_beats_clear_irq got=%b exp=1", irq_b); n_fail++; end
    bus_read(2'd3);
    n_checks++;
    if (bus_b.readdata !== 32'h2) begin
      $display("FAIL set_beats_clear_cap got=%h exp=%h", bus_b.readdata, 32'h2); n_fail++;
    end
  endtask

  task automatic test_debounce;
    bus_write(4'b0100, 2'd2, 32'h1);
    in_c = 4'b0001;
    tick(3);
    in_c = 4'b0000;
    tick(8);
    bus_read(2'd0);
    n_checks++;
    if (bus_c.readdata !== 32'h0) begin
      $display("FAIL glitch_data got=%h exp=%h", bus_c.readdata, 32'h0); n_fail++;
    end
    bus_read(2'd3);
    n_checks++;
    if (bus_c.readdata !== 32'h0) begin
      $display("FAIL glitch_edge got=%h exp=%h", bus_c.readdata, 32'h0); n_fail++;
    end
    addr = 2'd0;
    in_c = 4'b0001;
    tick(5);
    n_checks++;
    if (irq_c !== 1'b0) begin $display("FAIL debounce_early got=%b exp=0", irq_c); n_fail++; end
    tick(1);
    n_checks++;
    if (irq_c !== 1'b1) begin $display("FAIL debounce_accept got=%b exp=1", irq_c); n_fail++; end
    in_c = 4'b0000;
    bus_read(2'd0);
    n_checks++;
    if (bus_c.readdata !== 32'h1) begin
      $display("FAIL debounce_data got=%h exp=%h", bus_c.readdata, 32'h1); n_fail++;
    end
    tick(10);
  endtask

  task automatic test_width;
    bus_write(4'b1000, 2'd0, 32'hFFFF_FFFF);
    bus_read(2'd0);
    n_checks++;
    if (bus_d.readdata !== 32'h0) begin
      $display("FAIL data_write_ignored got=%h exp=%h", bus_d.readdata, 32'h0); n_fail++;
    end
    in_d = 32'hA5A5_A5A5;
    tick(5);
    bus_read(2'd0);
    n_checks++;
    if (bus_d.readdata !== 32'hA5A5_A5A5) begin
      $display("FAIL data_w32 got=%h exp=%h", bus_d.readdata, 32'hA5A5_A5A5); n_fail++;
    end
    bus_read(2'd3);
    n_checks++;
    if (bus_d.readdata !== 32'hA5A5_A5A5) begin
      $display("FAIL edgecap_any_rise got=%h exp=%h", bus_d.readdata, 32'hA5A5_A5A5); n_fail++;
    end
    bus_write(4'b1000, 2'd3, 32'hFFFF_FFFF);
    bus_read(2'd3);
    n_checks++;
    if (bus_d.readdata !== 32'h0) begin
      $display("FAIL edgecap_w32_clear got=%h exp=%h", bus_d.readdata, 32'h0); n_fail++;
    end
    in_d = 32'h0;
    tick(5);
    bus_read(2'd3);
    n_checks++;
    if (bus_d.readdata !== 32'hA5A5_A5A5) begin
      $display("FAIL edgecap_any_fall got=%h exp=%h", bus_d.readdata, 32'hA5A5_A5A5); n_fail++;
    end
    bus_write(4'b1000, 2'd1, 32'hFFFF_FFFF);
    bus_read(2'd1);
    n_checks++;
    if (bus_d.readdata !== 32'h0) begin
      $display("FAIL reserved_reads_zero got=%h exp=%h", bus_d.readdata, 32'h0); n_fail++;
    end
  endtask

  task automatic test_reset_mid;
    logic seen;
    in_c = 4'hF;
    tick(10);
    bus_read(2'd3);
    n_checks++;
    if (bus_c.readdata !== 32'hF) begin
      $display("FAIL pre_reset_edgecap got=%h exp=%h", bus_c.readdata, 32'hF); n_fail++;
    end
    in_c = 4'h0;
    tick(3);
    rst_c = 1'b1;
    tick(1);
    rst_c = 1'b0;
    n_checks++;
    if (bus_c.readdata !== 32'h0) begin
      $display("FAIL mid_reset_readdata got=%h exp=%h", bus_c.readdata, 32'h0); n_fail++;
    end
    n_checks++;
    if (irq_c !== 1'b0) begin $display("FAIL mid_reset_irq got=%b exp=0", irq_c); n_fail++; end
    bus_read(2'd3);
    n_checks++;
    if (bus_c.readdata !== 32'h0) begin
      $display("FAIL mid_reset_edgecap got=%h exp=%h", bus_c.readdata, 32'h0); n_fail++;
    end
    bus_read(2'd2);
    n_checks++;
    if (bus_c.readdata !== 32'h0) begin
      $display("FAIL mid_reset_mask got=%h exp=%h", bus_c.readdata, 32'h0); n_fail++;
    end
    bus_read(2'd0);
    n_checks++;
    if (bus_c.readdata !== 32'h0) begin
      $display("FAIL mid_reset_data got=%h exp=%h", bus_c.readdata, 32'h0); n_fail++;
    end
    bus_write(4'b0100, 2'd2, 32'hF);
    seen = 1'b0;
    in_c = 4'hF;
    for (int i = 0; i < 3; i++) begin tick(1); seen = seen | irq_c; end
    in_c = 4'h0;
    for (int i = 0; i < 10; i++) begin tick(1); seen = seen | irq_c; end
    n_checks++;
    if (seen !== 1'b0) begin $display("FAIL post_reset_glitch_irq got=%b exp=0", seen); n_fail++; end
    bus_read(2'd3);
    n_checks++;
    if (bus_c.readdata !== 32'h0) begin
      $display("FAIL post_reset_glitch_edge got=%h exp=%h", bus_c.readdata, 32'h0); n_fail++;
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    cs       = 4'b0;
    wr_n     = 1'b1;
    addr     = 2'd0;
    wdata    = 32'h0;
    rst      = 1'b1;
    rst_c    = 1'b1;
    in_a     = 4'h0;
    in_b     = 4'h0;
    in_c     = 4'h0;
    in_d     = 32'h0;
    #2;
    test_reset();
    test_level_irq();
    test_edge_irq();
    test_debounce();
    test_width();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
